text_console_writer: RTL and testbench
======================================

Name: text_console_writer

Overview:
- Writer side of the 80x60 text-mode character RAM that the VGA text output reads. The VGA side fetches cells by `characterPos = {col[6:0], row[5:0]}`.
- Accepts a byte stream from the CPU through a valid/ready handshake and writes printable characters, with fg/bg colour, at a hardware cursor.
- Interprets CR, LF, BS and FF.
- Scrolls the screen by copying rows up through a second RAM port.

Parameters:
- COLS, 80, characters per row; column field is 7 bits.
- ROWS, 60, rows per screen; row field is 6 bits.
- CLEAR_CHAR, 8'h20, character written by clear, scroll-fill and BS.

Ports:
- clk  in  1  system clock (same 31.5 MHz domain as the video RAM)
- reset  in  1  synchronous, active-high reset
- inData  in  8  character or control byte
- inValid  in  1  byte present
- inReady  out  1  block can accept a byte this cycle
- fgColor  in  3  foreground colour, sampled on accept
- bgColor  in  3  background colour, sampled on accept
- memWrAddr  out  13  write address `{col[6:0], row[5:0]}`
- memWrData  out  14  `{char[7:0], fg[2:0], bg[2:0]}`
- memWe  out  1  write strobe, one cell per cycle
- memRdAddr  out  13  read address, same layout; RAM returns data 1 cycle later
- memRdData  in  14  read data
- cursorPos  out  13  current cursor `{col, row}`
- busy  out  1  scroll or clear in progress

Behaviour:
- Reset, synchronous, checked before all else:
  - State goes to CLEAR_SCREEN with a clear pointer at (0,0).
  - cursorPos=0, memWe=0, memWrAddr=0, memWrData=0, memRdAddr=0, inReady=0, busy=1.
  - Reset asserted mid-scroll aborts the scroll and restarts the full clear.
- States: IDLE, CLEAR_SCREEN, SCROLL_COPY, SCROLL_CLEAR.
- `inReady = (state==IDLE) && !reset`. A byte is accepted when inValid && inReady. inData and the colours are held by the sender until accepted.
- IDLE accept, by byte value (all outputs below are registered, appearing 1 cycle after accept):
  - 0x20..0x7F:
    - memWe=1, memWrAddr=cursor, memWrData={inData, fgColor, bgColor}.
    - Cursor then advances: col+1. If col==COLS-1, col=0 and row+1.
    - If row was ROWS-1, row stays ROWS-1 and the block enters SCROLL_COPY.
  - 0x0D CR: col=0, no write.
  - 0x0A LF: col=0, row+1. If row==ROWS-1, row stays and the block enters SCROLL_COPY. No write.
  - 0x08 BS:
    - If col>0: col-1, and write CLEAR_CHAR with the sampled colours at the new position.
    - If col==0: no change, no write. BS never moves to the previous row.
  - 0x0C FF: cursor=(0,0), enter CLEAR_SCREEN.
  - Any other byte: consumed and ignored (no write, no cursor change).
- SCROLL_COPY:
  - Walks dst row 0..ROWS-2 and col 0..COLS-1, column-major inner loop.
  - Each cycle: memRdAddr={col,row+1}. Next cycle: memWe=1, memWrAddr={col,row}, memWrData=memRdData. The walk is pipelined, one cell per cycle.
  - After the last read, one drain cycle completes the final write, then the block enters SCROLL_CLEAR.
  - Total 80*59+1 = 4721 cycles.
- SCROLL_CLEAR: 80 writes of {CLEAR_CHAR, last fg, last bg} to row ROWS-1, cols 0..79, then IDLE.
- CLEAR_SCREEN: 4800 writes, one per cycle, of {CLEAR_CHAR, 3'b111, 3'b000} over all cells, then IDLE.
- memWe is 0 in every cycle not listed above. memWrAddr/memWrData are don't-care when memWe=0.
- cursorPos updates on the accept edge and is never outside 0..79 × 0..59.
- `busy = (state != IDLE)`.
- Colour bits are passed through untouched. Control codes ignore colour except BS and scroll-fill.
- A write to the same address the VGA side is reading needs no special handling; the RAM is true dual-port.

Test Plan:
- Reset held 2 cycles, released → exactly 4800 memWe pulses with data 14'h0838 at addresses covering all `{0..79, 0..59}`; then inReady=1, cursorPos=0.
- Send 'A' (0x41), fg=3'b010, bg=3'b001 at cursor (0,0) → one cycle later memWe=1, memWrAddr=0, memWrData={8'h41,3'b010,3'b001}; cursorPos={7'd1,6'd0}.
- Send 80 × 'x' starting at (0,5) → 80 writes at cols 0..79 of row 5; final cursorPos={7'd0,6'd6}.
- Cursor (10,3); send BS → write CLEAR_CHAR at {7'd10-1=9, 3}, cursor (9,3). Then CR → cursor (0,3), no write. Then BS → no write, cursor unchanged.
- Preload RAM row r with char 0x30+r%10; cursor (5,59); send LF → busy=1 and inReady=0 for 4721+80 cycles; row 0 holds 0x31, row 58 holds 0x39 (old row 59); row 59 is all 0x20; cursor (0,59).
- Assert reset 100 cycles into a scroll → no further copy writes; full 4800-cell clear restarts on the next cycle after reset deasserts.

Source files
------------

// File: rtl/text_console_writer_if.sv
// ============================================================================
//  text_console_writer_if
//  Byte-stream input, video character RAM ports and status of the console writer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

interface text_console_writer_if;
  logic [7:0]  inData;
  logic        inValid;
  logic        inReady;
  logic [2:0]  fgColor;
  logic [2:0]  bgColor;
  logic [12:0] memWrAddr;
  logic [13:0] memWrData;
  logic        memWe;
  logic [12:0] memRdAddr;
  logic [13:0] memRdData;
  logic [12:0] cursorPos;
  logic        busy;

  modport slave (
    input  inData, inValid, fgColor, bgColor, memRdData,
    output inReady, memWrAddr, memWrData, memWe, memRdAddr, cursorPos, busy
  );

  modport master (
    output inData, inValid, fgColor, bgColor, memRdData,
    input  inReady, memWrAddr, memWrData, memWe, memRdAddr, cursorPos, busy
  );
endinterface

`default_nettype wire

// File: rtl/text_console_writer.sv
// ============================================================================
//  text_console_writer
//  Writes CPU bytes into the 80x60 text RAM at a cursor; handles CR/LF/BS/FF,
//  scrolling and screen clear.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module text_console_writer #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 60,
  parameter logic [7:0] CLEAR_CHAR = 8'h20
) (
  input  logic                 clk,
  input  logic                 reset,
  text_console_writer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    CLEAR_SCREEN = 2'd1,
    SCROLL_COPY  = 2'd2,
    SCROLL_CLEAR = 2'd3
  } state_t;

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [5:0] LAST_ROW = 6'(ROWS - 1);

  state_t      state, state_nxt;
  logic [6:0]  cur_col, cur_col_nxt;
  logic [5:0]  cur_row, cur_row_nxt;
  logic [6:0]  ptr_col, ptr_col_nxt;
  logic [5:0]  ptr_row, ptr_row_nxt;
  logic [2:0]  last_fg, last_fg_nxt;
  logic [2:0]  last_bg, last_bg_nxt;
  logic        copy_pend, copy_pend_nxt;
  logic        drain, drain_nxt;
  logic [12:0] pend_addr, pend_addr_nxt;
  logic        we, we_nxt;
  logic [12:0] wr_addr, wr_addr_nxt;
  logic [13:0] wr_data, wr_data_nxt;
  logic        accept;
  logic        start_scroll;

  assign bus.inReady   = (state == IDLE) && !reset;
  assign accept        = bus.inValid && bus.inReady;
  assign bus.busy      = (state != IDLE);
  assign bus.cursorPos = {cur_col, cur_row};
  // The walk pointer is itself the read address, so read data arrives exactly
  // one cycle after the pointer cell is visited.
  assign bus.memRdAddr = {ptr_col, ptr_row};
  assign bus.memWe     = we;
  assign bus.memWrAddr = wr_addr;
  assign bus.memWrData = wr_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR_SCREEN;
      cur_col   <= '0;
      cur_row   <= '0;
      ptr_col   <= '0;
      ptr_row   <= '0;
      last_fg   <= '0;
      last_bg   <= '0;
      copy_pend <= 1'b0;
      drain     <= 1'b0;
      pend_addr <= '0;
      we        <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else begin
      state     <= state_nxt;
      cur_col   <= cur_col_nxt;
      cur_row   <= cur_row_nxt;
      ptr_col   <= ptr_col_nxt;
      ptr_row   <= ptr_row_nxt;
      last_fg   <= last_fg_nxt;
      last_bg   <= last_bg_nxt;
      copy_pend <= copy_pend_nxt;
      drain     <= drain_nxt;
      pend_addr <= pend_addr_nxt;
      we        <= we_nxt;
      wr_addr   <= wr_addr_nxt;
      wr_data   <= wr_data_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cur_col_nxt   = cur_col;
    cur_row_nxt   = cur_row;
    ptr_col_nxt   = ptr_col;
    ptr_row_nxt   = ptr_row;
    last_fg_nxt   = last_fg;
    last_bg_nxt   = last_bg;
    copy_pend_nxt = copy_pend;
    drain_nxt     = drain;
    pend_addr_nxt = pend_addr;
    we_nxt        = 1'b0;
    wr_addr_nxt   = wr_addr;
    wr_data_nxt   = wr_data;
    start_scroll  = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          last_fg_nxt = bus.fgColor;
          last_bg_nxt = bus.bgColor;
          if ((bus.inData >= 8'h20) && (bus.inData <= 8'h7F)) begin
            we_nxt      = 1'b1;
            wr_addr_nxt = {cur_col, cur_row};
            wr_data_nxt = {bus.inData, bus.fgColor, bus.bgColor};
            if (cur_col == LAST_COL) begin
              cur_col_nxt = '0;
              if (cur_row == LAST_ROW) start_scroll = 1'b1;
              else                     cur_row_nxt  = cur_row + 6'd1;
            end else begin
              cur_col_nxt = cur_col + 7'd1;
            end
          end else begin
            case (bus.inData)
              8'h0D: cur_col_nxt = '0;
              8'h0A: begin
                cur_col_nxt = '0;
                if (cur_row == LAST_ROW) start_scroll = 1'b1;
                else                     cur_row_nxt  = cur_row + 6'd1;
              end
              8'h08: begin
                // Backspace stops at column 0; it never wraps to the previous row.
                if (cur_col != 7'd0) begin
                  cur_col_nxt = cur_col - 7'd1;
                  we_nxt      = 1'b1;
                  wr_addr_nxt = {cur_col - 7'd1, cur_row};
                  wr_data_nxt = {CLEAR_CHAR, bus.fgColor, bus.bgColor};
                end
              end
              8'h0C: begin
                cur_col_nxt = '0;
                cur_row_nxt = '0;
                ptr_col_nxt = '0;
                ptr_row_nxt = '0;
                state_nxt   = CLEAR_SCREEN;
              end
              default: ;
            endcase
          end
          if (start_scroll) begin
            state_nxt     = SCROLL_COPY;
            ptr_col_nxt   = '0;
            ptr_row_nxt   = 6'd1;
            copy_pend_nxt = 1'b0;
            drain_nxt     = 1'b0;
          end
        end
      end

      CLEAR_SCREEN: begin
        we_nxt      = 1'b1;
        wr_addr_nxt = {ptr_col, ptr_row};
        wr_data_nxt = {CLEAR_CHAR, 3'b111, 3'b000};
        if (ptr_col == LAST_COL) begin
          ptr_col_nxt = '0;
          if (ptr_row == LAST_ROW) begin
            ptr_row_nxt = '0;
            state_nxt   = IDLE;
          end else begin
            ptr_row_nxt = ptr_row + 6'd1;
          end
        end else begin
          ptr_col_nxt = ptr_col + 7'd1;
        end
      end

      SCROLL_COPY: begin
        // Write side lags the read pointer by one cell; pend_addr is the
        // destination of the read issued in the previous cycle.
        we_nxt      = copy_pend;
        wr_addr_nxt = pend_addr;
        wr_data_nxt = bus.memRdData;
        if (drain) begin
          copy_pend_nxt = 1'b0;
          drain_nxt     = 1'b0;
          ptr_col_nxt   = '0;
          ptr_row_nxt   = LAST_ROW;
          state_nxt     = SCROLL_CLEAR;
        end else begin
          copy_pend_nxt = 1'b1;
          pend_addr_nxt = {ptr_col, ptr_row - 6'd1};
          if ((ptr_col == LAST_COL) && (ptr_row == LAST_ROW)) begin
            drain_nxt = 1'b1;
          end else if (ptr_col == LAST_COL) begin
            ptr_col_nxt = '0;
            ptr_row_nxt = ptr_row + 6'd1;
          end else begin
            ptr_col_nxt = ptr_col + 7'd1;
          end
        end
      end

      SCROLL_CLEAR: begin
        we_nxt      = 1'b1;
        wr_addr_nxt = {ptr_col, LAST_ROW};
        wr_data_nxt = {CLEAR_CHAR, last_fg, last_bg};
        if (ptr_col == LAST_COL) begin
          ptr_col_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          ptr_col_nxt = ptr_col + 7'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_text_console_writer.sv
// ============================================================================
//  tb_text_console_writer
//  Randomised bench for text_console_writer with a RAM model and screen model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_text_console_writer;
  localparam int COLS = 80;
  localparam int ROWS = 60;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  text_console_writer_if bus_if ();

  text_console_writer #(.COLS(COLS), .ROWS(ROWS), .CLEAR_CHAR(8'h20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  // True dual-port video RAM with one-cycle read latency
  logic [13:0] mem [0:8191];
  always @(posedge clk) begin
    if (bus_if.memWe) mem[bus_if.memWrAddr] <= bus_if.memWrData;
    bus_if.memRdData <= mem[bus_if.memRdAddr];
  end

  // Screen model: cell contents indexed [row][col] and a cursor
  logic [13:0] scr [ROWS][COLS];
  int          mcol, mrow;
  logic [2:0]  mfg, mbg;

  function automatic logic [12:0] a(input int c, input int r);
    return {7'(c), 6'(r)};
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) scr[r][c] = 14'h0838;
    mcol = 0;
    mrow = 0;
  endfunction

  function automatic void model_newline();
    if (mrow == ROWS - 1) begin
      for (int r = 0; r < ROWS - 1; r++)
        for (int c = 0; c < COLS; c++) scr[r][c] = scr[r + 1][c];
      for (int c = 0; c < COLS; c++) scr[ROWS - 1][c] = {8'h20, mfg, mbg};
    end else begin
      mrow++;
    end
  endfunction

  // Returns {we, addr, data, cursor} expected one cycle after accepting d
  function automatic logic [40:0] model_apply(input logic [7:0] d, input logic [2:0] fg, input logic [2:0] bg);
    logic        w  = 1'b0;
    logic [12:0] wa = 13'd0;
    logic [13:0] wd = 14'd0;
    mfg = fg;
    mbg = bg;
    if (d >= 8'h20 && d <= 8'h7F) begin
      w = 1'b1; wa = a(mcol, mrow); wd = {d, fg, bg};
      scr[mrow][mcol] = wd;
      mcol++;
      if (mcol == COLS) begin
        mcol = 0;
        model_newline();
      end
    end else if (d == 8'h0D) begin
      mcol = 0;
    end else if (d == 8'h0A) begin
      mcol = 0;
      model_newline();
    end else if (d == 8'h08) begin
      if (mcol > 0) begin
        mcol--;
        w = 1'b1; wa = a(mcol, mrow); wd = {8'h20, fg, bg};
        scr[mrow][mcol] = wd;
      end
    end else if (d == 8'h0C) begin
      model_clear();
    end
    return {w, wa, wd, a(mcol, mrow)};
  endfunction

  function automatic logic [40:0] sample();
    return {bus_if.memWe,
            bus_if.memWe ? bus_if.memWrAddr : 13'd0,
            bus_if.memWe ? bus_if.memWrData : 14'd0,
            bus_if.cursorPos};
  endfunction

  // Called and returns at a negedge; obs is sampled one cycle after accept
  task automatic send_byte(input logic [7:0] d, input logic [2:0] fg, input logic [2:0] bg,
                           output logic [40:0] obs);
    int n = 0;
    while (!bus_if.inReady && n < 10000) begin
      @(negedge clk);
      n++;
    end
    if (!bus_if.inReady) begin
      checks++; errors++;
      $display("FAIL send_timeout: inReady=%b after %0d cycles, required 1", bus_if.inReady, n);
    end
    bus_if.inData  = d;
    bus_if.fgColor = fg;
    bus_if.bgColor = bg;
    bus_if.inValid = 1'b1;
    @(posedge clk);
    #1 bus_if.inValid = 1'b0;
    @(negedge clk);
    obs = sample();
  endtask

  // Tallies clear writes until inReady rises
  task automatic count_clear(output int nwe, output int bad, output int cov);
    bit seen [8192];
    nwe = 0; bad = 0; cov = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      if (bus_if.memWe) begin
        nwe++;
        if (bus_if.memWrData !== 14'h0838) bad++;
        if (bus_if.memWrAddr[12:6] >= 7'd80 || bus_if.memWrAddr[5:0] >= 6'd60) bad++;
        seen[bus_if.memWrAddr] = 1'b1;
      end
      if (bus_if.inReady) break;
      @(negedge clk);
    end
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) if (seen[a(c, r)]) cov++;
  endtask

  task automatic do_ff(output logic [40:0] obs, output logic [40:0] exp, output int nwe, output int bad, output int cov);
    logic [2:0] fg = 3'($urandom);
    logic [2:0] bg = 3'($urandom);
    exp = model_apply(8'h0C, fg, bg);
    send_byte(8'h0C, fg, bg, obs);
    count_clear(nwe, bad, cov);
  endtask

  task automatic test_reset();
    int nwe, bad, cov;
    reset = 1'b1;
    bus_if.inValid = 1'b0;
    bus_if.inData = 8'h00; bus_if.fgColor = 3'd0; bus_if.bgColor = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus_if.memWe, bus_if.inReady, bus_if.busy, bus_if.cursorPos, bus_if.memWrAddr, bus_if.memWrData, bus_if.memRdAddr}
        !== {1'b0, 1'b0, 1'b1, 13'd0, 13'd0, 14'd0, 13'd0}) begin
      errors++;
      $display("FAIL reset_state: we=%b rdy=%b busy=%b cur=%h wa=%h wd=%h ra=%h, required 0 0 1 0 0 0 0",
               bus_if.memWe, bus_if.inReady, bus_if.busy, bus_if.cursorPos, bus_if.memWrAddr, bus_if.memWrData, bus_if.memRdAddr);
    end
    reset = 1'b0;
    count_clear(nwe, bad, cov);
    model_clear();
    checks++;
    if (nwe !== 4800 || bad !== 0 || cov !== 4800) begin
      errors++;
      $display("FAIL reset_clear: writes=%0d bad=%0d covered=%0d, required 4800 0 4800", nwe, bad, cov);
    end
    checks++;
    if (bus_if.inReady !== 1'b1 || bus_if.cursorPos !== 13'd0 || bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: rdy=%b cur=%h busy=%b, required 1 0 0", bus_if.inReady, bus_if.cursorPos, bus_if.busy);
    end
  endtask

  task automatic test_single_char();
    logic [40:0] obs, exp;
    exp = model_apply(8'h41, 3'b010, 3'b001);
    send_byte(8'h41, 3'b010, 3'b001, obs);
    checks++;
    if (obs !== {1'b1, 13'd0, 8'h41, 3'b010, 3'b001, 7'd1, 6'd0}) begin
      errors++;
      $display("FAIL single_char: got %h required %h", obs, {1'b1, 13'd0, 8'h41, 3'b010, 3'b001, 7'd1, 6'd0});
    end
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL single_char_model: got %h required %h", obs, exp);
    end
  endtask

  task automatic test_random_text();
    logic [40:0] obs, exp;
    logic [7:0]  d;
    logic [2:0]  fg, bg;
    int          k, bad;
    for (int i = 0; i < 200; i++) begin
      k  = int'($urandom_range(0, 99));
      fg = 3'($urandom);
      bg = 3'($urandom);
      if (k < 70)      d = 8'($urandom_range(32, 127));
      else if (k < 75) d = 8'h0D;
      else if (k < 79) d = 8'h0A;
      else if (k < 90) d = 8'h08;
      else begin
        d = 8'($urandom_range(0, 255));
        if (d == 8'h0C) d = 8'h01;
      end
      exp = model_apply(d, fg, bg);
      send_byte(d, fg, bg, obs);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL random_text[%0d] byte %h: got %h required %h", i, d, obs, exp);
      end
    end
    @(posedge clk);
    @(negedge clk);
    bad = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) if (mem[a(c, r)] !== scr[r][c]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random_text_screen: %0d cells differ, required 0", bad);
    end
  endtask

  task automatic test_line_fill();
    logic [40:0] obs, exp;
    logic [2:0]  fg, bg;
    int          nwe, bad, cov;
    do_ff(obs, exp, nwe, bad, cov);
    checks++;
    if (obs !== exp || nwe !== 4800 || bad !== 0 || cov !== 4800) begin
      errors++;
      $display("FAIL form_feed: obs=%h writes=%0d bad=%0d cov=%0d, required %h 4800 0 4800", obs, nwe, bad, cov, exp);
    end
    for (int i = 0; i < 5; i++) begin
      exp = model_apply(8'h0A, 3'd0, 3'd0);
      send_byte(8'h0A, 3'd0, 3'd0, obs);
    end
    for (int i = 0; i < 80; i++) begin
      fg = 3'($urandom); bg = 3'($urandom);
      exp = model_apply(8'h78, fg, bg);
      send_byte(8'h78, fg, bg, obs);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL line_fill[%0d]: got %h required %h", i, obs, exp);
      end
    end
    checks++;
    if (bus_if.cursorPos !== {7'd0, 6'd6}) begin
      errors++;
      $display("FAIL line_fill_cursor: got %h required %h", bus_if.cursorPos, {7'd0, 6'd6});
    end
    @(posedge clk);
    @(negedge clk);
    bad = 0;
    for (int c = 0; c < COLS; c++) if (mem[a(c, 5)][13:6] !== 8'h78) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL line_fill_row: %0d cells not 'x', required 0", bad);
    end
  endtask

  task automatic test_backspace();
    logic [40:0] obs, exp;
    logic [2:0]  fg, bg;
    int          nwe, bad, cov;
    do_ff(obs, exp, nwe, bad, cov);
    for (int i = 0; i < 3; i++) begin
      exp = model_apply(8'h0A, 3'd1, 3'd2);
      send_byte(8'h0A, 3'd1, 3'd2, obs);
    end
    for (int i = 0; i < 10; i++) begin
      exp = model_apply(8'h61, 3'd3, 3'd4);
      send_byte(8'h61, 3'd3, 3'd4, obs);
    end
    fg = 3'($urandom); bg = 3'($urandom);
    exp = model_apply(8'h08, fg, bg);
    send_byte(8'h08, fg, bg, obs);
    checks++;
    if (obs !== {1'b1, 7'd9, 6'd3, 8'h20, fg, bg, 7'd9, 6'd3} || obs !== exp) begin
      errors++;
      $display("FAIL bs_write: got %h required %h", obs, {1'b1, 7'd9, 6'd3, 8'h20, fg, bg, 7'd9, 6'd3});
    end
    exp = model_apply(8'h0D, fg, bg);
    send_byte(8'h0D, fg, bg, obs);
    checks++;
    if (obs !== {1'b0, 13'd0, 14'd0, 7'd0, 6'd3}) begin
      errors++;
      $display("FAIL cr: got %h required %h", obs, {1'b0, 13'd0, 14'd0, 7'd0, 6'd3});
    end
    exp = model_apply(8'h08, fg, bg);
    send_byte(8'h08, fg, bg, obs);
    checks++;
    if (obs !== {1'b0, 13'd0, 14'd0, 7'd0, 6'd3}) begin
      errors++;
      $display("FAIL bs_col0: got %h required %h", obs, {1'b0, 13'd0, 14'd0, 7'd0, 6'd3});
    end
  endtask

  task automatic test_scroll();
    logic [40:0] obs, exp;
    logic [2:0]  fg, bg;
    logic [7:0]  ch;
    int          nwe, bad, cov, nbusy, nrdy, bad_top, bad_last;
    do_ff(obs, exp, nwe, bad, cov);
    // Row r carries digit r%10 with random colours; last cell of row 59 stays clear
    for (int i = 0; i < 59 * 80 + 79 + 6; i++) begin
      fg = 3'($urandom); bg = 3'($urandom);
      if (i == 59 * 80 + 79) ch = 8'h0D;
      else if (i < 59 * 80)  ch = 8'h30 + 8'((i / 80) % 10);
      else                   ch = 8'h39;
      exp = model_apply(ch, fg, bg);
      send_byte(ch, fg, bg, obs);
      if (obs !== exp) begin
        checks++; errors++;
        $display("FAIL scroll_preload[%0d]: got %h required %h", i, obs, exp);
      end
    end
    checks++;
    if (bus_if.cursorPos !== {7'd5, 6'd59}) begin
      errors++;
      $display("FAIL scroll_precursor: got %h required %h", bus_if.cursorPos, {7'd5, 6'd59});
    end
    fg = 3'($urandom); bg = 3'($urandom);
    exp = model_apply(8'h0A, fg, bg);
    send_byte(8'h0A, fg, bg, obs);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL scroll_lf: got %h required %h", obs, exp);
    end
    nbusy = 0; nwe = 0; nrdy = 0;
    while (bus_if.busy && nbusy < 10000) begin
      nbusy++;
      if (bus_if.memWe) nwe++;
      if (bus_if.inReady) nrdy++;
      @(negedge clk);
    end
    if (bus_if.memWe) nwe++;
    checks++;
    if (nbusy !== 4721 + 80 || nrdy !== 0 || nwe !== 4800) begin
      errors++;
      $display("FAIL scroll_timing: busy=%0d rdy=%0d writes=%0d, required 4801 0 4800", nbusy, nrdy, nwe);
    end
    @(posedge clk);
    @(negedge clk);
    bad_top = 0; bad_last = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (mem[a(c, r)] !== scr[r][c]) begin
          if (r == ROWS - 1) bad_last++; else bad_top++;
        end
    checks++;
    if (bad_top != 0) begin
      errors++;
      $display("FAIL scroll_copy: %0d cells differ in rows 0..58, required 0", bad_top);
    end
    checks++;
    if (bad_last != 0) begin
      errors++;
      $display("FAIL scroll_fill: %0d cells differ in row 59, required 0", bad_last);
    end
    checks++;
    if (mem[a(0, 0)][13:6] !== 8'h31 || mem[a(0, 58)][13:6] !== 8'h39 || mem[a(40, 59)] !== {8'h20, fg, bg}) begin
      errors++;
      $display("FAIL scroll_cells: row0=%h row58=%h row59=%h, required 31 39 %h",
               mem[a(0, 0)][13:6], mem[a(0, 58)][13:6], mem[a(40, 59)], {8'h20, fg, bg});
    end
    checks++;
    if (bus_if.cursorPos !== {7'd0, 6'd59}) begin
      errors++;
      $display("FAIL scroll_cursor: got %h required %h", bus_if.cursorPos, {7'd0, 6'd59});
    end
  endtask

  task automatic test_reset_mid_scroll();
    logic [40:0] obs, exp;
    int          nwe, bad, cov;
    exp = model_apply(8'h0A, 3'd5, 3'd6);
    send_byte(8'h0A, 3'd5, 3'd6, obs);
    repeat (100) @(negedge clk);
    checks++;
    if (bus_if.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_scroll_busy: got %b required 1", bus_if.busy);
    end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({bus_if.memWe, bus_if.inReady, bus_if.busy, bus_if.cursorPos} !== {1'b0, 1'b0, 1'b1, 13'd0}) begin
        errors++;
        $display("FAIL mid_reset_state[%0d]: we=%b rdy=%b busy=%b cur=%h, required 0 0 1 0",
                 i, bus_if.memWe, bus_if.inReady, bus_if.busy, bus_if.cursorPos);
      end
    end
    reset = 1'b0;
    model_clear();
    @(negedge clk);
    checks++;
    if (bus_if.memWe !== 1'b1 || bus_if.memWrAddr !== 13'd0 || bus_if.memWrData !== 14'h0838) begin
      errors++;
      $display("FAIL mid_reset_restart: we=%b addr=%h data=%h, required 1 0000 0838",
               bus_if.memWe, bus_if.memWrAddr, bus_if.memWrData);
    end
    count_clear(nwe, bad, cov);
    checks++;
    if (nwe !== 4800 || bad !== 0 || cov !== 4800 || bus_if.inReady !== 1'b1 || bus_if.cursorPos !== 13'd0) begin
      errors++;
      $display("FAIL mid_reset_clear: writes=%0d bad=%0d cov=%0d rdy=%b cur=%h, required 4800 0 4800 1 0",
               nwe, bad, cov, bus_if.inReady, bus_if.cursorPos);
    end
  endtask

  initial begin
    test_reset();
    test_single_char();
    test_random_text();
    test_line_fill();
    test_backspace();
    test_scroll();
    test_reset_mid_scroll();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
